// File: rtl/pattern_pkg.sv
// Shared encodings, palette and sizing helper for the VGA test-pattern generator.
package pattern_pkg;

    typedef enum logic [1:0] {
        MODE_HSTRIPE = 2'd0,
        MODE_VSTRIPE = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_CYCLE   = 2'd3
    } mode_e;

    localparam logic [11:0] PALETTE [0:7] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFFF,
        12'hFF0, 12'h0FF, 12'hF0F, 12'h888
    };

    localparam logic [11:0] CHK_A = 12'hFFF;
    localparam logic [11:0] CHK_B = 12'h000;

    function automatic logic [11:0] palette_lookup(input logic [2:0] idx);
        return PALETTE[idx];
    endfunction

    // Width of a counter that holds 0..n-1 (never zero bits wide).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Video-side bundle between vga_ctrl, the pattern generator and its controller.
interface pattern_gen_if;

    logic [1:0]  mode;
    logic        scroll_en;
    logic [3:0]  scroll_step;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        valid;
    logic        vsync;
    logic [11:0] vga_data;
    logic        frame_tick;

    modport master (
        output mode, scroll_en, scroll_step, h_addr, v_addr, valid, vsync,
        input  vga_data, frame_tick
    );

    modport slave (
        input  mode, scroll_en, scroll_step, h_addr, v_addr, valid, vsync,
        output vga_data, frame_tick
    );

endinterface

// File: rtl/band_counter.sv
// Position-within-band counter with a wrapping band index; next-state values are
// exported so the colour select can use them in the same cycle as the address.
module band_counter
    import pattern_pkg::*;
#(
    parameter  int BAND       = 80,
    parameter  int NUM_COLORS = 3,
    localparam int PW         = cnt_width(BAND)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [PW-1:0] load_pos,
    input  logic [2:0]    load_band,
    input  logic          adv,
    output logic [PW-1:0] pos,
    output logic [2:0]    band,
    output logic [PW-1:0] pos_nxt,
    output logic [2:0]    band_nxt
);

    logic [PW-1:0] pos_q, pos_d;
    logic [2:0]    band_q, band_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        pos_d  = pos_q;
        band_d = band_q;
        if (load) begin
            pos_d  = load_pos;
            band_d = load_band;
        end else if (adv) begin
            if (pos_q == PW'(BAND - 1)) begin
                pos_d  = '0;
                band_d = (band_q == 3'(NUM_COLORS - 1)) ? 3'd0 : band_q + 3'd1;
            end else begin
                pos_d = pos_q + PW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q  <= '0;
            band_q <= '0;
        end else begin
            pos_q  <= pos_d;
            band_q <= band_d;
        end
    end

    assign pos      = pos_q;
    assign band     = band_q;
    assign pos_nxt  = pos_d;
    assign band_nxt = band_d;

endmodule

// File: rtl/pattern_gen.sv
// VGA test-pattern generator: stripes, checkerboard and colour cycle driven from
// vga_ctrl pixel addresses, with divider-free band tracking and per-frame scroll.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int H_BAND          = 80,
    parameter int V_BAND          = 80,
    parameter int NUM_COLORS      = 3,
    parameter int FRAMES_PER_STEP = 60
) (
    input  logic          clk,
    input  logic          reset,
    pattern_gen_if.slave  bus
);

    localparam int RPW = cnt_width(V_BAND);
    localparam int CPW = cnt_width(H_BAND);
    localparam int FW  = cnt_width(FRAMES_PER_STEP);

    localparam logic [9:0] H_ACT_W = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_W = 10'(V_ACTIVE);

    logic            vsync_q;
    mode_e           mode_q, mode_d;
    logic [RPW-1:0]  row_pos0_q, row_pos0_d;
    logic [2:0]      row_band0_q, row_band0_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [2:0]      cyc_idx_q, cyc_idx_d;
    logic [9:0]      last_h_q, last_v_q;
    logic [11:0]     vga_data_q, vga_data_d;
    logic            frame_tick_q;

    logic            boundary;
    logic            new_h, new_v;
    int              step_i, sum_i;

    logic [RPW-1:0]  row_pos, row_pos_nxt;
    logic [CPW-1:0]  col_pos, col_pos_nxt;
    logic [2:0]      row_band, row_band_nxt, col_band, col_band_nxt;
    logic            unused_cnt;

    assign boundary = vsync_q & ~bus.vsync;
    assign new_h    = (bus.h_addr != last_h_q);
    assign new_v    = (bus.v_addr != last_v_q);

    // Frame-rate state: mode, scroll phase and colour-cycle position move only here.
    always_comb begin
        mode_d      = mode_q;
        row_pos0_d  = row_pos0_q;
        row_band0_d = row_band0_q;
        frame_cnt_d = frame_cnt_q;
        cyc_idx_d   = cyc_idx_q;
        step_i      = 0;
        if (bus.scroll_en) begin
            step_i = (int'(bus.scroll_step) < V_BAND - 1) ? int'(bus.scroll_step) : V_BAND - 1;
        end
        sum_i = int'(row_pos0_q) + step_i;
        if (boundary) begin
            mode_d = mode_e'(bus.mode);
            if (sum_i >= V_BAND) begin
                row_pos0_d  = RPW'(sum_i - V_BAND);
                row_band0_d = (row_band0_q == 3'(NUM_COLORS - 1)) ? 3'd0 : row_band0_q + 3'd1;
            end else begin
                row_pos0_d = RPW'(sum_i);
            end
            if (frame_cnt_q == FW'(FRAMES_PER_STEP - 1)) begin
                frame_cnt_d = '0;
                cyc_idx_d   = (cyc_idx_q == 3'(NUM_COLORS - 1)) ? 3'd0 : cyc_idx_q + 3'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    band_counter #(.BAND(V_BAND), .NUM_COLORS(NUM_COLORS)) u_row (
        .clk       (clk),
        .reset     (reset),
        .load      (new_v && (bus.v_addr == 10'd0)),
        .load_pos  (row_pos0_q),
        .load_band (row_band0_q),
        .adv       (new_v && (bus.v_addr < V_ACT_W)),
        .pos       (row_pos),
        .band      (row_band),
        .pos_nxt   (row_pos_nxt),
        .band_nxt  (row_band_nxt)
    );

    band_counter #(.BAND(H_BAND), .NUM_COLORS(NUM_COLORS)) u_col (
        .clk       (clk),
        .reset     (reset),
        .load      (new_h && (bus.h_addr == 10'd0)),
        .load_pos  ('0),
        .load_band (3'd0),
        .adv       (new_h && (bus.h_addr < H_ACT_W)),
        .pos       (col_pos),
        .band      (col_band),
        .pos_nxt   (col_pos_nxt),
        .band_nxt  (col_band_nxt)
    );

    // Only the look-ahead band indices drive colour; positions are for visibility.
    assign unused_cnt = ^{row_pos, row_pos_nxt, col_pos, col_pos_nxt, row_band, col_band};

    always_comb begin
        vga_data_d = 12'h000;
        if (bus.valid && (bus.v_addr < V_ACT_W) && (bus.h_addr < H_ACT_W)) begin
            case (mode_q)
                MODE_HSTRIPE: vga_data_d = palette_lookup(row_band_nxt);
                MODE_VSTRIPE: vga_data_d = palette_lookup(col_band_nxt);
                MODE_CHECKER: vga_data_d = (row_band_nxt[0] ^ col_band_nxt[0]) ? CHK_B : CHK_A;
                default:      vga_data_d = palette_lookup(cyc_idx_q);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q      <= 1'b0;
            mode_q       <= MODE_HSTRIPE;
            row_pos0_q   <= '0;
            row_band0_q  <= '0;
            frame_cnt_q  <= '0;
            cyc_idx_q    <= '0;
            last_h_q     <= '0;
            last_v_q     <= '0;
            vga_data_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            vsync_q      <= bus.vsync;
            mode_q       <= mode_d;
            row_pos0_q   <= row_pos0_d;
            row_band0_q  <= row_band0_d;
            frame_cnt_q  <= frame_cnt_d;
            cyc_idx_q    <= cyc_idx_d;
            last_h_q     <= bus.h_addr;
            last_v_q     <= bus.v_addr;
            vga_data_q   <= vga_data_d;
            frame_tick_q <= boundary;
        end
    end

    assign bus.vga_data   = vga_data_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: scans reduced-size frames with randomised pixel hold times
// and compares every pixel against an arithmetic model of the pattern rules.
module tb_pattern_gen;

    localparam int HA      = 48;
    localparam int VA      = 32;
    localparam int HB      = 8;
    localparam int VB      = 8;
    localparam int NC      = 3;
    localparam int FPS     = 2;
    localparam int HT      = 52;
    localparam int VT      = 35;
    localparam int VS_LINE = 33;

    localparam logic [11:0] PAL [0:7] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFFF,
        12'hFF0, 12'h0FF, 12'hF0F, 12'h888
    };

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pattern_gen_if bus ();

    pattern_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BAND(HB), .V_BAND(VB),
        .NUM_COLORS(NC), .FRAMES_PER_STEP(FPS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: total scroll offset in lines, boundaries since reset, latched mode.
    int   m_mode;
    int   m_offset;
    int   m_frames;
    logic m_prev_vs;

    bit   force_blank = 1'b0;
    bit   gaps        = 1'b0;
    logic [11:0] obs [VA][HA];

    function automatic logic [11:0] golden(input int h, input int v, input bit vld);
        int rb, cb;
        if (!vld || h >= HA || v >= VA) return 12'h000;
        rb = ((v + m_offset) / VB) % NC;
        cb = (h / HB) % NC;
        case (m_mode)
            0:       return PAL[rb];
            1:       return PAL[cb];
            2:       return (((rb ^ cb) & 1) != 0) ? 12'h000 : 12'hFFF;
            default: return PAL[(m_frames / FPS) % NC];
        endcase
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_offset  = 0;
        m_frames  = 0;
        m_prev_vs = 1'b0;
    endtask

    task automatic model_boundary();
        int st;
        m_mode = int'(bus.mode);
        st = 0;
        if (bus.scroll_en) st = (int'(bus.scroll_step) < VB - 1) ? int'(bus.scroll_step) : VB - 1;
        m_offset = (m_offset + st) % (VB * NC);
        m_frames++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset       = 1'b1;
        bus.h_addr  = '0;
        bus.v_addr  = '0;
        bus.valid   = 1'b0;
        bus.vsync   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One full frame, vsync low on VS_LINE; optional mid-frame mode write or reset pulse.
    task automatic scan_frame(input bit chk, input int mid_mode, input bit mid_reset);
        bit          live;
        bit          vs, vld;
        int          hold, ticks;
        logic [11:0] exp;
        live  = chk;
        ticks = 0;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                if (mid_mode >= 0 && v == VA / 2 && h == 0) bus.mode = 2'(mid_mode);
                vs  = (v != VS_LINE);
                vld = (h < HA) && (v < VA) && !force_blank && !(gaps && $urandom_range(0, 7) == 0);
                bus.h_addr = 10'(h);
                bus.v_addr = 10'(v);
                bus.valid  = vld;
                bus.vsync  = vs;
                if (m_prev_vs && !vs) model_boundary();
                m_prev_vs = vs;
                exp  = golden(h, v, vld);
                hold = ($urandom_range(0, 3) == 0) ? 2 : 1;
                repeat (hold) begin
                    @(negedge clk);
                    if (bus.frame_tick === 1'b1) ticks++;
                    if (live) begin
                        checks++;
                        if (bus.vga_data !== exp) begin
                            errors++;
                            $display("FAIL pixel h=%0d v=%0d mode=%0d: vga_data=%h expected %h",
                                     h, v, m_mode, bus.vga_data, exp);
                        end
                    end
                end
                if (h < HA && v < VA) obs[v][h] = bus.vga_data;
                if (mid_reset && v == VA / 2 && h == HA / 2) begin
                    reset = 1'b1;
                    #1;
                    checks += 2;
                    if (bus.vga_data !== 12'h000) begin
                        errors++;
                        $display("FAIL mid_reset_async: vga_data=%h expected 000", bus.vga_data);
                    end
                    if (bus.frame_tick !== 1'b0) begin
                        errors++;
                        $display("FAIL mid_reset_tick: frame_tick=%b expected 0", bus.frame_tick);
                    end
                    repeat (3) begin
                        @(negedge clk);
                        checks++;
                        if (bus.vga_data !== 12'h000) begin
                            errors++;
                            $display("FAIL mid_reset_hold: vga_data=%h expected 000", bus.vga_data);
                        end
                    end
                    reset = 1'b0;
                    model_reset();
                    live = 1'b0;
                end
            end
        end
        if (live) begin
            checks++;
            if (ticks !== 1) begin
                errors++;
                $display("FAIL frame_tick_count: saw %0d pulses, expected 1", ticks);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.h_addr = 10'($urandom_range(0, HT - 1));
            bus.v_addr = 10'($urandom_range(0, VA - 1));
            bus.valid  = 1'b1;
            bus.vsync  = i[0];
            bus.mode   = 2'($urandom_range(0, 3));
            @(negedge clk);
            checks += 2;
            if (bus.vga_data !== 12'h000) begin
                errors++;
                $display("FAIL reset_data: vga_data=%h expected 000", bus.vga_data);
            end
            if (bus.frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_tick: frame_tick=%b expected 0", bus.frame_tick);
            end
        end
        apply_reset();
    endtask

    task automatic test_hstripe();
        int vs_list [6] = '{0, 7, 8, 16, 24, 31};
        logic [11:0] want [6] = '{12'hF00, 12'hF00, 12'h0F0, 12'h00F, 12'hF00, 12'hF00};
        apply_reset();
        bus.mode = 2'd0;
        bus.scroll_en = 1'b0;
        bus.scroll_step = 4'd0;
        scan_frame(1'b1, -1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[vs_list[i]][5] !== want[i]) begin
                errors++;
                $display("FAIL hstripe v=%0d: got %h expected %h", vs_list[i], obs[vs_list[i]][5], want[i]);
            end
        end
    endtask

    task automatic test_vstripe();
        int hs_list [4] = '{0, 8, 16, 47};
        logic [11:0] want [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'h00F};
        bus.mode = 2'd1;
        scan_frame(1'b1, -1, 1'b0);
        scan_frame(1'b1, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[3][hs_list[i]] !== want[i]) begin
                errors++;
                $display("FAIL vstripe h=%0d: got %h expected %h", hs_list[i], obs[3][hs_list[i]], want[i]);
            end
        end
    endtask

    task automatic test_checker();
        bus.mode = 2'd2;
        scan_frame(1'b1, -1, 1'b0);
        scan_frame(1'b1, -1, 1'b0);
        checks += 3;
        if (obs[0][0] !== 12'hFFF) begin
            errors++; $display("FAIL checker_0_0: got %h expected FFF", obs[0][0]);
        end
        if (obs[0][8] !== 12'h000) begin
            errors++; $display("FAIL checker_8_0: got %h expected 000", obs[0][8]);
        end
        if (obs[8][8] !== 12'hFFF) begin
            errors++; $display("FAIL checker_8_8: got %h expected FFF", obs[8][8]);
        end
    endtask

    task automatic test_scroll();
        apply_reset();
        bus.mode = 2'd0;
        bus.scroll_en = 1'b1;
        bus.scroll_step = 4'd4;
        scan_frame(1'b1, -1, 1'b0);
        scan_frame(1'b1, -1, 1'b0);
        checks += 2;
        if (obs[3][0] !== 12'hF00) begin
            errors++; $display("FAIL scroll4_v3: got %h expected F00", obs[3][0]);
        end
        if (obs[4][0] !== 12'h0F0) begin
            errors++; $display("FAIL scroll4_v4: got %h expected 0F0", obs[4][0]);
        end
        bus.scroll_step = 4'd15;
        scan_frame(1'b1, -1, 1'b0);
        checks++;
        if (obs[0][0] !== 12'h0F0) begin
            errors++; $display("FAIL scroll_offset8_v0: got %h expected 0F0", obs[0][0]);
        end
        scan_frame(1'b1, -1, 1'b0);
        checks += 2;
        if (obs[0][0] !== 12'h0F0) begin
            errors++; $display("FAIL scroll_clamp_v0: got %h expected 0F0", obs[0][0]);
        end
        if (obs[1][0] !== 12'h00F) begin
            errors++; $display("FAIL scroll_clamp_v1: got %h expected 00F", obs[1][0]);
        end
        bus.scroll_en = 1'b0;
    endtask

    task automatic test_mode_change();
        apply_reset();
        bus.mode = 2'd0;
        scan_frame(1'b1, -1, 1'b0);
        scan_frame(1'b1, 1, 1'b0);
        checks++;
        if (obs[VA-1][8] !== 12'hF00) begin
            errors++; $display("FAIL mode_change_same_frame: got %h expected F00", obs[VA-1][8]);
        end
        scan_frame(1'b1, -1, 1'b0);
        checks++;
        if (obs[VA-1][8] !== 12'h0F0) begin
            errors++; $display("FAIL mode_change_next_frame: got %h expected 0F0", obs[VA-1][8]);
        end
    endtask

    task automatic test_cycle();
        apply_reset();
        bus.mode = 2'd3;
        scan_frame(1'b1, -1, 1'b0);
        scan_frame(1'b1, -1, 1'b0);
        checks++;
        if (obs[10][20] !== 12'hF00) begin
            errors++; $display("FAIL cycle_first: got %h expected F00", obs[10][20]);
        end
        scan_frame(1'b1, -1, 1'b0);
        checks++;
        if (obs[10][20] !== 12'h0F0) begin
            errors++; $display("FAIL cycle_step: got %h expected 0F0", obs[10][20]);
        end
        force_blank = 1'b1;
        scan_frame(1'b1, -1, 1'b0);
        force_blank = 1'b0;
        checks++;
        if (obs[10][20] !== 12'h000) begin
            errors++; $display("FAIL blank_valid0: got %h expected 000", obs[10][20]);
        end
    endtask

    task automatic test_reset_mid_frame();
        bus.mode = 2'd1;
        scan_frame(1'b1, -1, 1'b1);
        scan_frame(1'b1, -1, 1'b0);
    endtask

    task automatic test_random();
        gaps = 1'b1;
        for (int f = 0; f < 4; f++) begin
            bus.mode        = 2'($urandom_range(0, 3));
            bus.scroll_en   = 1'($urandom_range(0, 1));
            bus.scroll_step = 4'($urandom_range(0, 15));
            scan_frame(1'b1, -1, 1'b0);
        end
        gaps = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.mode        = 2'd0;
        bus.scroll_en   = 1'b0;
        bus.scroll_step = 4'd0;
        bus.h_addr      = '0;
        bus.v_addr      = '0;
        bus.valid       = 1'b0;
        bus.vsync       = 1'b1;
        model_reset();
        test_reset();
        test_hstripe();
        test_vstripe();
        test_checker();
        test_scroll();
        test_mode_change();
        test_cycle();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
